bnn_neuron_driver: RTL and testbench
====================================

BNN_NEURON_DRIVER -- requirements
Module: bnn_neuron_driver

Interface
REQ-001 SHALL have parameter N_WORDS, default 4: number of 8-bit words per activation vector, legal range 1..16.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-high; the codebase port name is retained.
REQ-004 SHALL have ports wr_en (in, 1), wr_addr (in, 4), wr_data (in, 8): weight-bank write port.
REQ-005 SHALL have ports in_data (in, 8), in_valid (in, 1), in_ready (out, 1): activation stream; a word transfers when valid and ready are both 1.
REQ-006 SHALL have ports n_clr (out, 1), n_data (out, 8), n_weight (out, 8): these drive the neuron's reset, input_data and weight.
REQ-007 SHALL have port n_out, input, 1: the neuron's registered output o_neuron.
REQ-008 SHALL have ports out_data (out, 8), out_valid (out, 1), out_ready (in, 1): result byte handshake.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-010 SHALL hold a weight bank of N_WORDS x 8 bits.
- Write occurs when wr_en=1 and wr_addr<N_WORDS, in any state.
- Writes with wr_addr>=N_WORDS are ignored.
- A write to the entry streamed in the same cycle takes effect next cycle; the old value is streamed.
REQ-011 SHALL implement FSM states IDLE, LOAD, CLEAR, STREAM, WAIT, EMIT.
REQ-012 IDLE: in_ready=1; an accepted word is stored at buf[0], word count becomes 1, next state is LOAD (or CLEAR if N_WORDS=1).
REQ-013 LOAD: in_ready=1; each accepted word goes to buf[count]; after word N_WORDS-1 is accepted, next state is CLEAR; gaps in in_valid only stall.
REQ-014 in_ready SHALL be 0 in CLEAR, STREAM, WAIT and EMIT.
REQ-015 CLEAR: exactly 1 cycle with n_clr=1.
REQ-016 STREAM: exactly N_WORDS cycles; in cycle i, n_data=buf[i] and n_weight=wbank[i]; n_clr=0.
REQ-017 Outside STREAM, n_data SHALL be 0x00 and n_weight SHALL be 0xFF, giving an XNOR contribution of zero.
REQ-018 WAIT: exactly 2 cycles.
- n_out is sampled at the end of the second WAIT cycle, which accounts for the neuron's 2-cycle accumulate-plus-output latency.
- The sampled value is written to result[k], where k is the 0-based vector index.
REQ-019 After WAIT, k increments; if k reaches 8, next state is EMIT, otherwise IDLE.
REQ-020 EMIT: out_valid=1 and out_data=result; both held stable until out_ready=1. On handshake: k=0, result=0, next state IDLE.
REQ-021 out_valid SHALL be 0 in every state except EMIT.
REQ-022 Minimum per-vector latency, from the last input word accepted to the n_out sample, SHALL be 1+N_WORDS+2 cycles.

Reset
REQ-023 rst_n=1 at a clock edge SHALL force:
- state=IDLE, k=0, word count=0, result=0x00;
- all weight-bank entries and buf entries to 0x00;
- out_valid=0, in_ready=0 during reset, busy=0;
- n_clr=1, n_data=0x00, n_weight=0xFF.
REQ-024 Reset asserted mid-operation (any state) SHALL abandon the vector and the partial result; no out_valid pulse follows.
REQ-025 in_ready SHALL go to 1 on the first cycle after rst_n deasserts.

Verification
REQ-026 Stream order: N_WORDS=4, weights 0x11,0x22,0x33,0x44, input 0xA0..0xA3 -> n_clr high 1 cycle, then 4 cycles of (A0,11),(A1,22),(A2,33),(A3,44), then 0x00/0xFF.
REQ-027 Result packing: 8 vectors with n_out model returning 1,0,1,1,0,0,0,1 -> out_data=0x8D, out_valid rises after the 8th WAIT.
REQ-028 Backpressure: out_ready held 0 for 10 cycles in EMIT -> out_valid and out_data stay stable, in_ready=0; handshake returns the block to IDLE with result cleared.
REQ-029 Input gaps plus address bounds:
- in_valid toggled 1,0,0,1,... -> only valid beats are stored, and the stream matches.
- wr_addr=4 (with N_WORDS=4) -> no bank change.
REQ-030 Reset mid-STREAM: rst_n=1 on stream cycle 2 -> next cycle IDLE, n_data=0x00, n_weight=0xFF, busy=0; the next vector packs into result[0].

Source files
------------

// File: rtl/bnn_neuron_driver.sv
// Feeds one binarized neuron: buffers an activation vector, streams it with the weight bank,
// collects the neuron's output bit per vector and emits 8 results as one packed byte.
module bnn_neuron_driver #(
    parameter int N_WORDS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       n_clr,
    output logic [7:0] n_data,
    output logic [7:0] n_weight,
    input  logic       n_out,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);
    localparam logic [4:0] NW = 5'(N_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_STREAM, S_WAIT, S_EMIT
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] cnt;
    logic          wait_cnt;
    logic [2:0]    k;
    logic [7:0]    result;
    logic [7:0]    in_buf [0:DEPTH-1];
    logic [7:0]    wbank  [0:DEPTH-1];
    logic          in_fire;

    // Handshake: a word moves on any cycle where valid and ready are both high at the clock edge.
    assign in_fire   = in_valid && in_ready;
    assign in_ready  = !rst_n && (state == S_IDLE || state == S_LOAD);
    assign out_valid = (state == S_EMIT);
    assign out_data  = result;
    assign busy      = (state != S_IDLE);
    assign n_clr     = rst_n || (state == S_CLEAR);
    assign state_dbg = state;

    // Idle pattern 0x00 against 0xFF makes every XNOR bit zero, so the neuron accumulates nothing.
    assign n_data   = (state == S_STREAM) ? in_buf[cnt] : 8'h00;
    assign n_weight = (state == S_STREAM) ? wbank[cnt]  : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_fire) state_nxt = (N_WORDS == 1) ? S_CLEAR : S_LOAD;
            S_LOAD:   if (in_fire && cnt == LAST) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: if (cnt == LAST) state_nxt = S_WAIT;
            S_WAIT:   if (wait_cnt) state_nxt = (k == 3'd7) ? S_EMIT : S_IDLE;
            S_EMIT:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt      <= '0;
            wait_cnt <= 1'b0;
            k        <= 3'd0;
            result   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                in_buf[i] <= 8'h00;
                wbank[i]  <= 8'h00;
            end
        end else begin
            // Read side is combinational, so a same-cycle write streams the old weight.
            if (wr_en && ({1'b0, wr_addr} < NW))
                wbank[wr_addr[IW-1:0]] <= wr_data;
            case (state)
                S_IDLE: if (in_fire) begin
                    in_buf[0] <= in_data;
                    cnt       <= IW'(1);
                end
                S_LOAD: if (in_fire) begin
                    in_buf[cnt] <= in_data;
                    cnt         <= cnt + 1'b1;
                end
                S_CLEAR:  cnt <= '0;
                S_STREAM: cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                S_WAIT: begin
                    // Second wait cycle covers the neuron's accumulate-then-register latency.
                    wait_cnt <= ~wait_cnt;
                    if (wait_cnt) begin
                        result[k] <= n_out;
                        k         <= k + 1'b1;
                    end
                end
                S_EMIT: if (out_ready) begin
                    k      <= 3'd0;
                    result <= 8'h00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_neuron_driver.sv
// Bench for bnn_neuron_driver: directed and randomized vectors against a cycle-level
// model of the stream/result behaviour, with a queue of expected result bytes.
module tb_bnn_neuron_driver;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       n_clr;
    logic [7:0] n_data;
    logic [7:0] n_weight;
    logic       n_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    bnn_neuron_driver #(.N_WORDS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .n_clr(n_clr), .n_data(n_data), .n_weight(n_weight), .n_out(n_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .state_dbg(state_dbg)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] wm [0:15];
    logic [7:0] res_model;
    int         k_model;
    logic [7:0] exp_q[$];

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic rand_write(input bit en);
        if (en && $urandom_range(0, 3) == 0) begin
            wr_en   = 1'b1;
            wr_addr = 4'($urandom_range(0, 7));
            wr_data = 8'($urandom);
        end else begin
            wr_en = 1'b0;
        end
    endtask

    // Advance one clock and mirror any bank write the DUT should have taken at that edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n && wr_en && wr_addr < 4'(N)) wm[wr_addr] = wr_data;
    endtask

    function automatic logic [8*N-1:0] rand_vec();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) wm[i] = 8'h00;
        res_model = 8'h00;
        k_model   = 0;
    endtask

    // gap_mode: 0 none, 1 two idle beats before every word after the first, 2 random idles
    task automatic run_vector(input logic [8*N-1:0] vec, input logic bitv,
                              input int gap_mode, input bit wr_rand);
        for (int i = 0; i < N; i++) begin
            int gaps;
            gaps = (gap_mode == 1 && i > 0) ? 2 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                n_out    = 1'($urandom);
                rand_write(wr_rand);
                #1;
                chk1("gap_in_ready", in_ready, 1'b1);
                chk1("gap_busy", busy, (i > 0));
                chk1("gap_out_valid", out_valid, 1'b0);
                step();
            end
            in_valid = 1'b1;
            in_data  = vec[8*i +: 8];
            n_out    = 1'($urandom);
            rand_write(wr_rand);
            #1;
            chk1("load_in_ready", in_ready, 1'b1);
            chk1("load_busy", busy, (i > 0));
            chk1("load_out_valid", out_valid, 1'b0);
            step();
        end
        // Cycle 0 clears, cycles 1..N stream, cycles N+1 and N+2 wait; n_out matters only at the last.
        for (int j = 0; j < N + 3; j++) begin
            logic [7:0] ed, ew;
            if (j >= 1 && j <= N) begin
                ed = vec[8*(j-1) +: 8];
                ew = wm[j-1];
            end else begin
                ed = 8'h00;
                ew = 8'hFF;
            end
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            n_out    = (j == N + 2) ? bitv : ~bitv;
            rand_write(wr_rand);
            #1;
            chk1("n_clr", n_clr, (j == 0));
            chk8("n_data", n_data, ed);
            chk8("n_weight", n_weight, ew);
            chk1("busy_run", busy, 1'b1);
            chk1("in_ready_run", in_ready, 1'b0);
            chk1("out_valid_run", out_valid, 1'b0);
            step();
        end
        in_valid = 1'b0;
        wr_en    = 1'b0;
        res_model[k_model] = bitv;
        k_model++;
        if (k_model == 8) begin
            exp_q.push_back(res_model);
            res_model = 8'h00;
            k_model   = 0;
        end
    endtask

    task automatic run_emit(input int hold);
        logic [7:0] e;
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            rand_write(1'b1);
            #1;
            chk1("emit_hold_valid", out_valid, 1'b1);
            chk8("emit_hold_data", out_data, e);
            chk1("emit_in_ready", in_ready, 1'b0);
            chk1("emit_busy", busy, 1'b1);
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wr_en     = 1'b0;
        #1;
        chk1("emit_valid", out_valid, 1'b1);
        chk8("emit_data", out_data, e);
        step();
        out_ready = 1'b0;
        #1;
        chk1("post_emit_valid", out_valid, 1'b0);
        chk1("post_emit_busy", busy, 1'b0);
        chk1("post_emit_ready", in_ready, 1'b1);
    endtask

    task automatic run_batch(input int hold);
        for (int v = 0; v < 8; v++)
            run_vector(rand_vec(), 1'($urandom), int'($urandom_range(0, 2)), 1'b1);
        run_emit(hold);
    endtask

    initial begin
        logic [7:0] bits1;
        logic [8*N-1:0] vec;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
        in_data = 8'h00; in_valid = 1'b0; n_out = 1'b0; out_ready = 1'b0;
        model_reset();

        step();
        step();
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_n_clr", n_clr, 1'b1);
        chk8("rst_n_data", n_data, 8'h00);
        chk8("rst_n_weight", n_weight, 8'hFF);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("post_rst_ready", in_ready, 1'b1);
        chk1("post_rst_n_clr", n_clr, 1'b0);

        // Weights 0x11..0x44, then an out-of-range write that must not land anywhere.
        for (int a = 0; a < 5; a++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(a);
            wr_data = (a < 4) ? 8'((a + 1) * 17) : 8'h99;
            step();
        end
        wr_en = 1'b0;

        bits1 = 8'b1000_1101;
        run_vector({8'hA3, 8'hA2, 8'hA1, 8'hA0}, bits1[0], 0, 1'b0);
        run_vector(rand_vec(), bits1[1], 1, 1'b0);
        for (int v = 2; v < 8; v++) run_vector(rand_vec(), bits1[v], 2, 1'b1);
        run_emit(10);

        run_batch(int'($urandom_range(0, 5)));
        run_batch(int'($urandom_range(0, 5)));

        // Partial batch, then reset during stream cycle 2 of the next vector.
        for (int v = 0; v < 3; v++) run_vector(rand_vec(), 1'($urandom), 0, 1'b1);
        vec = rand_vec();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = vec[8*i +: 8];
            step();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) rst_n = 1'b1;
            #1;
            if (j >= 1) chk8("abort_stream_data", n_data, vec[8*(j-1) +: 8]);
            step();
        end
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk8("abort_n_data", n_data, 8'h00);
        chk8("abort_n_weight", n_weight, 8'hFF);
        chk1("abort_in_ready", in_ready, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        model_reset();
        rst_n = 1'b0;
        #1;
        chk1("abort_release_ready", in_ready, 1'b1);
        chk1("abort_release_valid", out_valid, 1'b0);

        run_batch(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
